// File: rtl/console_writer_pkg.sv
// Shared control codes, blank-cell attribute and writer FSM encoding for the text console path.
package console_writer_pkg;

    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_TAB   = 8'h09;
    localparam logic [7:0] CODE_LF    = 8'h0A;
    localparam logic [7:0] CODE_FF    = 8'h0C;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_SPACE = 8'h20;
    localparam logic [7:0] CODE_DEL   = 8'h7F;

    localparam logic [7:0] DEFAULT_ATTR = 8'h07;

    typedef enum logic {
        ST_FILL,
        ST_IDLE
    } wr_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CODE_SPACE) && (b != CODE_DEL);
    endfunction

endpackage

// File: rtl/console_fill_engine.sv
// Blank-fill sequencer: writes count consecutive cells starting at base_addr, one per cycle.
// Latency: first write the cycle after start; done is high during the last write.
// Backpressure: none; start is only honoured by the caller while the engine is idle.
module console_fill_engine #(
    parameter int AW = 11,
    parameter int NW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [NW-1:0] count,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          done
);

    logic [NW-1:0] remaining;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            remaining <= '0;
        end else if (start) begin
            mem_we    <= (count != '0);
            mem_addr  <= base_addr;
            remaining <= count;
        end else if (mem_we) begin
            remaining <= remaining - NW'(1);
            // Hold the address on the final cell so it never steps past the range.
            if (remaining == NW'(1)) begin
                mem_we <= 1'b0;
            end else begin
                mem_addr <= mem_addr + AW'(1);
            end
        end
    end

    assign done = mem_we && (remaining == NW'(1));

endmodule

// File: rtl/console_writer.sv
// Byte-stream to text-RAM writer with cursor, control codes, line wrap and ring-offset scroll.
// Latency: printable byte written 1 cycle after accept; sustains 1 byte/cycle while no fill runs.
// Backpressure: in_ready low for the whole of any blank fill (reset, form feed, scroll).
module console_writer
    import console_writer_pkg::*;
#(
    parameter int         COLUMNS           = 80,
    parameter int         ROWS              = 25,
    parameter logic [7:0] DEFAULT_ATTRIBUTE = DEFAULT_ATTR,
    parameter int         TAB_STOP          = 8,
    localparam int        AW                = $clog2(COLUMNS*ROWS),
    localparam int        RW                = $clog2(ROWS),
    localparam int        CW                = $clog2(COLUMNS)
) (
    input  logic          clk_pixel,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic [7:0]    in_attr,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic [RW-1:0] row_offset,
    output logic [CW-1:0] cursor_x,
    output logic [RW-1:0] cursor_y
);

    localparam int          CELLS  = COLUMNS * ROWS;
    localparam int          NW     = $clog2(CELLS + 1);
    localparam logic [RW:0] ROWS_W = (RW+1)'(ROWS);

    wr_state_t     state_q, state_d;
    logic [CW-1:0] cx_d;
    logic [RW-1:0] cy_d, off_d;
    logic          fill_pend_q, fill_pend_d;
    logic          fill_all_q, fill_all_d;
    logic [AW-1:0] fill_base_q, fill_base_d;
    logic          wr_we_q, wr_we_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;

    logic          fill_start, fill_we, fill_done;
    logic [AW-1:0] fill_addr;
    logic [RW:0]   row_sum;
    logic [RW-1:0] phys_row;
    logic [AW-1:0] cell_addr;
    logic [CW:0]   tab_x;
    logic          newline;
    logic          accept;

    assign in_ready   = (state_q == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign fill_start = (state_q == ST_FILL) && fill_pend_q;

    console_fill_engine #(
        .AW (AW),
        .NW (NW)
    ) u_fill (
        .clk       (clk_pixel),
        .reset     (reset),
        .start     (fill_start),
        .base_addr (fill_base_q),
        .count     (fill_all_q ? NW'(CELLS) : NW'(COLUMNS)),
        .mem_we    (fill_we),
        .mem_addr  (fill_addr),
        .done      (fill_done)
    );

    // Character writes and fills never overlap, so the fill simply takes priority.
    assign mem_we    = fill_we | wr_we_q;
    assign mem_addr  = fill_we ? fill_addr : wr_addr_q;
    assign mem_wdata = fill_we ? {DEFAULT_ATTRIBUTE, CODE_SPACE} : wr_data_q;

    always_comb begin
        row_sum = {1'b0, row_offset} + {1'b0, cursor_y};
        if (row_sum >= ROWS_W) begin
            phys_row = RW'(row_sum - ROWS_W);
        end else begin
            phys_row = row_sum[RW-1:0];
        end
        cell_addr = AW'(int'(phys_row) * COLUMNS + int'(cursor_x));
        tab_x     = ({1'b0, cursor_x} | (CW+1)'(TAB_STOP - 1)) + (CW+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        cx_d        = cursor_x;
        cy_d        = cursor_y;
        off_d       = row_offset;
        fill_pend_d = fill_start ? 1'b0 : fill_pend_q;
        fill_all_d  = fill_all_q;
        fill_base_d = fill_base_q;
        wr_we_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        newline     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (fill_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (accept) begin
                    if (is_printable(in_byte)) begin
                        wr_we_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_data_d = {in_attr, in_byte};
                        if (cursor_x == CW'(COLUMNS - 1)) begin
                            cx_d    = '0;
                            newline = 1'b1;
                        end else begin
                            cx_d = cursor_x + CW'(1);
                        end
                    end else begin
                        case (in_byte)
                            CODE_CR: cx_d = '0;
                            CODE_LF: newline = 1'b1;
                            CODE_BS: begin
                                if (cursor_x != '0) begin
                                    cx_d = cursor_x - CW'(1);
                                end
                            end
                            CODE_TAB: begin
                                if (tab_x >= (CW+1)'(COLUMNS)) begin
                                    cx_d    = '0;
                                    newline = 1'b1;
                                end else begin
                                    cx_d = tab_x[CW-1:0];
                                end
                            end
                            CODE_FF: begin
                                cx_d        = '0;
                                cy_d        = '0;
                                off_d       = '0;
                                state_d     = ST_FILL;
                                fill_pend_d = 1'b1;
                                fill_all_d  = 1'b1;
                                fill_base_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // Scrolling: the old top physical row becomes the new bottom row and is blanked.
        if (newline) begin
            if (cursor_y < RW'(ROWS - 1)) begin
                cy_d = cursor_y + RW'(1);
            end else begin
                off_d       = (row_offset == RW'(ROWS - 1)) ? '0 : row_offset + RW'(1);
                state_d     = ST_FILL;
                fill_pend_d = 1'b1;
                fill_all_d  = 1'b0;
                fill_base_d = AW'(int'(row_offset) * COLUMNS);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q     <= ST_FILL;
            cursor_x    <= '0;
            cursor_y    <= '0;
            row_offset  <= '0;
            fill_pend_q <= 1'b1;
            fill_all_q  <= 1'b1;
            fill_base_q <= '0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cursor_x    <= cx_d;
            cursor_y    <= cy_d;
            row_offset  <= off_d;
            fill_pend_q <= fill_pend_d;
            fill_all_q  <= fill_all_d;
            fill_base_q <= fill_base_d;
            wr_we_q     <= wr_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer on an 8x4 screen with tab stop 4.
module tb_console_writer;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int TABS  = 4;
    localparam int CELLS = COLS * ROWS;
    localparam int LIM   = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic [7:0]  in_attr = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  row_offset;
    logic [2:0]  cursor_x;
    logic [1:0]  cursor_y;

    console_writer #(
        .COLUMNS           (COLS),
        .ROWS              (ROWS),
        .DEFAULT_ATTRIBUTE (8'h07),
        .TAB_STOP          (TABS)
    ) dut (
        .clk_pixel  (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_attr    (in_attr),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .row_offset (row_offset),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] scr[CELLS];
    logic [15:0] ram[CELLS];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mx = 0, my = 0, moff = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_we) begin
            ram[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                chk("spurious_we", {31'b0, mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {27'b0, mem_addr}, {27'b0, e.addr});
                chk("wr_data", {16'b0, mem_wdata}, {16'b0, e.data});
            end
        end
    end

    task automatic push_wr(input int addr, input logic [15:0] data);
        wr_t e;
        e.addr = addr[4:0];
        e.data = data;
        exp_q.push_back(e);
        scr[addr] = data;
    endtask

    task automatic push_fill(input int base, input int n);
        for (int i = 0; i < n; i++) push_wr(base + i, 16'h0720);
    endtask

    task automatic model_newline();
        if (my < ROWS - 1) begin
            my++;
        end else begin
            push_fill(moff * COLS, COLS);
            moff = (moff + 1) % ROWS;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic [7:0] a);
        if (b >= 8'h20 && b != 8'h7F) begin
            push_wr(((moff + my) % ROWS) * COLS + mx, {a, b});
            mx++;
            if (mx == COLS) begin
                mx = 0;
                model_newline();
            end
        end else begin
            case (b)
                8'h0D: mx = 0;
                8'h0A: model_newline();
                8'h08: if (mx > 0) mx--;
                8'h09: begin
                    mx = (mx | (TABS - 1)) + 1;
                    if (mx >= COLS) begin
                        mx = 0;
                        model_newline();
                    end
                end
                8'h0C: begin
                    mx = 0; my = 0; moff = 0;
                    push_fill(0, CELLS);
                end
                default: ;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] a);
        int n;
        in_valid = 1'b1;
        in_byte  = b;
        in_attr  = a;
        n = 0;
        while (!in_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model_byte(b, a);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic chk_cur(input string tag, input int x, input int y, input int off);
        chk({tag, "_x"}, {29'b0, cursor_x}, x);
        chk({tag, "_y"}, {30'b0, cursor_y}, y);
        chk({tag, "_off"}, {30'b0, row_offset}, off);
    endtask

    initial begin
        int n, c0, r;
        logic [7:0] b;
        logic [7:0] oth[4];
        oth[0] = 8'h00; oth[1] = 8'h01; oth[2] = 8'h1B; oth[3] = 8'h7F;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {27'b0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'b0, mem_wdata}, 32'd0);
        chk_cur("rst", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_fill(0, CELLS);
        n = 0;
        while (!in_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("clr_hold", {31'b0, n >= CELLS}, 32'd1);
        wait_idle();
        chk_cur("clr", 0, 0, 0);

        // First printable: written one cycle after accept
        send(8'h41, 8'h1E);
        chk("a_we", {31'b0, mem_we}, 32'd1);
        chk("a_addr", {27'b0, mem_addr}, 32'd0);
        chk("a_data", {16'b0, mem_wdata}, 32'h1E41);
        chk("a_x", {29'b0, cursor_x}, 32'd1);

        // Full row back-to-back, then backspace handling
        send(8'h0D, 8'h07);
        c0 = cyc;
        for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i), 8'h07);
        chk("b2b_cycles", cyc - c0, COLS);
        chk_cur("row0", 0, 1, 0);
        send(8'h5A, 8'h07);
        send(8'h08, 8'h07);
        send(8'h08, 8'h07);
        chk("bs2_x", {29'b0, cursor_x}, 32'd0);
        send(8'h08, 8'h07);
        chk("bs3_x", {29'b0, cursor_x}, 32'd0);

        // Tabs and carriage return
        send(8'h43, 8'h07);
        send(8'h09, 8'h07);
        chk("tab1_x", {29'b0, cursor_x}, 32'd4);
        send(8'h44, 8'h07);
        send(8'h09, 8'h07);
        chk("tab2_we", {31'b0, mem_we}, 32'd0);
        chk_cur("tab2", 0, 2, 0);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 8'h07);
        send(8'h0D, 8'h07);
        chk_cur("cr", 0, 2, 0);

        // Scroll on LF at the bottom row
        send(8'h0A, 8'h07);
        send(8'h0A, 8'h07);
        chk_cur("scroll", 0, 3, 1);
        chk("scroll_ready", {31'b0, in_ready}, 32'd0);
        wait_idle();
        send(8'h42, 8'h2F);
        chk("b_addr", {27'b0, mem_addr}, 32'd0);
        chk("b_data", {16'b0, mem_wdata}, 32'h2F42);

        // Reset in the middle of a row fill
        send(8'h0A, 8'h07);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mx = 0; my = 0; moff = 0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("midrst_we", {31'b0, mem_we}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd0);
        chk_cur("midrst", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_fill(0, CELLS);
        wait_idle();

        // Wrap on the last cell of the bottom row
        for (int i = 0; i < 3; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < COLS; i++) send(8'h70 + 8'(i), 8'h4E);
        chk("wrap_ready", {31'b0, in_ready}, 32'd0);
        wait_idle();
        chk_cur("wrap", 0, 3, 1);

        // Form feed
        send(8'h0C, 8'h07);
        chk_cur("ff", 0, 0, 0);
        wait_idle();

        // Random stream against the model
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60) b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(128, 255));
            else if (r < 68) b = 8'h0D;
            else if (r < 78) b = 8'h0A;
            else if (r < 85) b = 8'h08;
            else if (r < 93) b = 8'h09;
            else if (r < 95) b = 8'h0C;
            else b = oth[$urandom_range(0, 3)];
            send(b, 8'($urandom_range(0, 255)));
            chk_cur("rnd", mx, my, moff);
        end
        wait_idle();
        for (int i = 0; i < CELLS; i++) chk($sformatf("ram%0d", i), {16'b0, ram[i]}, {16'b0, scr[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
